sd_cmd_tx: RTL and testbench

Sequences the SD-card command path. Accepts a command index and argument and drives the team's 40-bit parallel CRC7 unit through its crc_en/complt handshake. Assembles the 48-bit command frame (start, transmission bit, index, argument, CRC7, end bit) and serialises it MSB-first onto the CMD line at a divided bit rate. Sits between the SD host command sequencer and the CMD pad.

---
 rtl/sd_cmd_tx.sv | 184 ++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SD-card command transmitter.
// Latches a command index and argument, obtains CRC7 from the external
// 40-bit CRC unit via the crc_en/crc_complt handshake, then shifts the
// 48-bit command frame MSB-first onto the CMD line. Each bit is held for
// CLKDIV clk cycles.
// Optional build macro: SD_CMD_NCC_GAP_EN keeps the line driven high for
// 8 extra bit periods after the end bit before releasing it.
module sd_cmd_tx #(
    parameter int CLKDIV      = 2,
    parameter int CRC_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        crc_en,
    output logic [39:0] crc_data,
    input  logic        crc_complt,
    input  logic [6:0]  crc_value,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe
);

`ifdef SD_CMD_NCC_GAP_EN
    typedef enum logic [1:0] {IDLE, CRC_WAIT, SHIFT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, CRC_WAIT, SHIFT} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] TMO_LAST = 8'(CRC_TIMEOUT - 1);

    state_t      state_q, state_n;
    logic [5:0]  idx_q, idx_n;
    logic [31:0] arg_q, arg_n;
    logic [47:0] frame_q, frame_n;
    logic [5:0]  bit_q, bit_n;
    logic [7:0]  div_q, div_n;
    logic [7:0]  tmo_q, tmo_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        err_q, err_n;
    logic        crc_en_q, crc_en_n;
    logic        oe_q, oe_n;

    // The frame register's MSB is the line value; it idles at all ones so the
    // released line and the NCC gap both read as 1.
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign crc_en    = crc_en_q;
    assign crc_data  = {2'b01, idx_q, arg_q};
    assign sd_cmd_o  = frame_q[47];
    assign sd_cmd_oe = oe_q;

    // State and datapath registers; async reset releases the line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            arg_q    <= '0;
            frame_q  <= '1;
            bit_q    <= '0;
            div_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            crc_en_q <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            arg_q    <= arg_n;
            frame_q  <= frame_n;
            bit_q    <= bit_n;
            div_q    <= div_n;
            tmo_q    <= tmo_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            err_q    <= err_n;
            crc_en_q <= crc_en_n;
            oe_q     <= oe_n;
        end
    end

    // Next-state and next-output logic; done/err are single-cycle pulses.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        arg_n    = arg_q;
        frame_n  = frame_q;
        bit_n    = bit_q;
        div_n    = div_q;
        tmo_n    = tmo_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        crc_en_n = crc_en_q;
        oe_n     = oe_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_n    = cmd_index;
                    arg_n    = cmd_arg;
                    busy_n   = 1'b1;
                    crc_en_n = 1'b1;
                    tmo_n    = '0;
                    state_n  = CRC_WAIT;
                end
            end

            CRC_WAIT: begin
                if (crc_complt) begin
                    frame_n  = {2'b01, idx_q, arg_q, crc_value, 1'b1};
                    oe_n     = 1'b1;
                    crc_en_n = 1'b0;
                    div_n    = '0;
                    bit_n    = '0;
                    state_n  = SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    crc_en_n = 1'b0;
                    busy_n   = 1'b0;
                    err_n    = 1'b1;
                    state_n  = IDLE;
                end else begin
                    tmo_n = tmo_q + 8'd1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    if (bit_q == 6'd47) begin
                        frame_n = '1;
                        bit_n   = '0;
`ifdef SD_CMD_NCC_GAP_EN
                        state_n = GAP;
`else
                        oe_n    = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        frame_n = {frame_q[46:0], 1'b1};
                        bit_n   = bit_q + 6'd1;
                    end
                end else begin
                    div_n = div_q + 8'd1;
                end
            end

`ifdef SD_CMD_NCC_GAP_EN
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    if (bit_q == 6'd7) begin
                        bit_n   = '0;
                        oe_n    = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_q + 6'd1;
                    end
                end else begin
                    div_n = div_q + 8'd1;
                end
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: self-checking bench for sd_cmd_tx.
// Three instances run with CLKDIV = 2, 1 and 5, each paired with a CRC7 unit
// model and a cycle-relative reference model of the expected CMD waveform.
module tb_sd_cmd_tx;

    localparam int NDUT = 3;
    localparam int TMO  = 8;
`ifdef SD_CMD_NCC_GAP_EN
    localparam int GAPB = 8;
`else
    localparam int GAPB = 0;
`endif

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    // Reference CRC7 (x^7 + x^3 + 1), bitwise over the 40 message bits.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NDUT-1:0]        start_v = '0;
    logic [NDUT-1:0]        stall_v = '0;
    logic [NDUT-1:0][5:0]   idx_v   = '0;
    logic [NDUT-1:0][31:0]  arg_v   = '0;
    logic [NDUT-1:0]        busy_v, done_v, err_v, crc_en_v, cmd_o_v, cmd_oe_v;
    logic [NDUT-1:0][39:0]  crc_data_v;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    // Edge counter; read only on negedges, where it equals the last posedge number.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int D = div_of(g);

        logic       complt;
        logic [6:0] crc_val;

        sd_cmd_tx #(.CLKDIV(D), .CRC_TIMEOUT(TMO)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_v[g]),
            .cmd_index  (idx_v[g]),
            .cmd_arg    (arg_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .err        (err_v[g]),
            .crc_en     (crc_en_v[g]),
            .crc_data   (crc_data_v[g]),
            .crc_complt (complt),
            .crc_value  (crc_val),
            .sd_cmd_o   (cmd_o_v[g]),
            .sd_cmd_oe  (cmd_oe_v[g])
        );

        // CRC unit: clears while disabled, computes once on the first enabled edge.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                complt  <= 1'b0;
                crc_val <= '0;
            end else if (!crc_en_v[g]) begin
                complt <= 1'b0;
            end else if (!stall_v[g] && !complt) begin
                complt  <= 1'b1;
                crc_val <= crc7(crc_data_v[g]);
            end
        end

        // Reference model: time since acceptance decides every output.
        bit          m_active = 1'b0;
        bit          m_tmo    = 1'b0;
        int          m_t      = 0;
        int          m_end    = 0;
        int          m_fin    = 0;
        logic [5:0]  m_idx    = '0;
        logic [31:0] m_arg    = '0;
        logic [47:0] m_frame  = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_active = 1'b0;
                m_fin    = 0;
            end else begin
                m_fin = 0;
                if (m_active) begin
                    m_t++;
                    if (m_t == m_end) begin
                        m_active = 1'b0;
                        m_fin    = m_tmo ? 2 : 1;
                    end
                end else if (start_v[g]) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    m_idx    = idx_v[g];
                    m_arg    = arg_v[g];
                    m_tmo    = stall_v[g];
                    m_end    = m_tmo ? TMO : 2 + (48 + GAPB) * D;
                    m_frame  = {2'b01, m_idx, m_arg, crc7({2'b01, m_idx, m_arg}), 1'b1};
                end
            end
        end

        logic e_crc_en, e_oe, e_o;
        int   b;

        // Compare every DUT output with the model on each falling edge.
        always @(negedge clk) begin
            if (chk_on) begin
                e_crc_en = m_active && (m_tmo || m_t < 2);
                e_oe     = m_active && !m_tmo && m_t >= 2;
                e_o      = 1'b1;
                if (e_oe) begin
                    b = (m_t - 2) / D;
                    if (b < 48) e_o = m_frame[47 - b];
                end
                checkOutput($sformatf("dut%0d busy", g),   busy_v[g],   m_active);
                checkOutput($sformatf("dut%0d crc_en", g), crc_en_v[g], e_crc_en);
                checkOutput($sformatf("dut%0d oe", g),     cmd_oe_v[g], e_oe);
                checkOutput($sformatf("dut%0d cmd_o", g),  cmd_o_v[g],  e_o);
                checkOutput($sformatf("dut%0d done", g),   done_v[g],   m_fin == 1);
                checkOutput($sformatf("dut%0d err", g),    err_v[g],    m_fin == 2);
                if (m_active)
                    checkOutput($sformatf("dut%0d crc_data", g), crc_data_v[g], {2'b01, m_idx, m_arg});
            end
        end
    end

    // Issue one command starting at the current negedge and follow it to done/err.
    // A second start with random fields is pulsed at relative cycle 'poke' (if > 0).
    task automatic applyStimulus(input int d, input logic [5:0] idx, input logic [31:0] arg,
                                 input int poke, output logic [47:0] cap, output int end_rel,
                                 output bit was_err, output int oe_cyc);
        int  e0, rel, dv;
        bit  ended;
        dv      = div_of(d);
        cap     = '0;
        end_rel = -1;
        was_err = 1'b0;
        oe_cyc  = 0;
        ended   = 1'b0;
        idx_v[d]   = idx;
        arg_v[d]   = arg;
        start_v[d] = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start_v[d] = 1'b0;
        idx_v[d]   = 6'($urandom);
        arg_v[d]   = $urandom;
        for (int k = 0; k < 2 + 56 * dv + 20; k++) begin
            rel = cyc - e0;
            start_v[d] = (poke > 0) && (rel == poke);
            if (start_v[d]) begin
                idx_v[d] = 6'($urandom);
                arg_v[d] = $urandom;
            end
            if (cmd_oe_v[d]) oe_cyc++;
            if (cmd_oe_v[d] && rel >= 2 && (rel - 2) % dv == 0 && (rel - 2) / dv < 48)
                cap = {cap[46:0], cmd_o_v[d]};
            if (done_v[d] || err_v[d]) begin
                end_rel = rel;
                was_err = err_v[d];
                ended   = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL dut%0d completion: no done/err within cycle budget", d);
        end
    endtask

    logic [47:0] cap;
    int          end_rel, oe_cyc, endx, dcnt;
    bit          was_err, stall;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset busy",   busy_v,   3'b000);
        checkOutput("reset done",   done_v,   3'b000);
        checkOutput("reset err",    err_v,    3'b000);
        checkOutput("reset crc_en", crc_en_v, 3'b000);
        checkOutput("reset oe",     cmd_oe_v, 3'b000);
        checkOutput("reset cmd_o",  cmd_o_v,  3'b111);
        rst    = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Pin the reference CRC against known command CRCs.
        checkOutput("crc7 CMD0",  crc7(40'h4000000000), 7'h4A);
        checkOutput("crc7 CMD17", crc7(40'h5100000000), 7'h2A);
        checkOutput("crc7 CMD8",  crc7(40'h48000001AA), 7'h43);

        // CMD0 at CLKDIV=2.
        applyStimulus(0, 6'd0, 32'h0, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("CMD0 frame", cap, 48'h400000000095);
        checkOutput("CMD0 done cycle", end_rel, 2 + (48 + GAPB) * 2);
        checkOutput("CMD0 oe cycles", oe_cyc, (48 + GAPB) * 2);
        checkOutput("CMD0 no err", was_err, 1'b0);

        // CMD17 at CLKDIV=1, CMD8 at CLKDIV=5.
        applyStimulus(1, 6'd17, 32'h0, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("CMD17 frame", cap, 48'h510000000055);
        checkOutput("CMD17 done cycle", end_rel, 2 + (48 + GAPB) * 1);
        applyStimulus(2, 6'd8, 32'h000001AA, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("CMD8 frame", cap, 48'h48000001AA87);
        checkOutput("CMD8 done cycle", end_rel, 2 + (48 + GAPB) * 5);
        checkOutput("CMD8 oe cycles", oe_cyc, (48 + GAPB) * 5);

        // CRC handshake stalls: timeout, then a normal command.
        stall_v[0] = 1'b1;
        applyStimulus(0, 6'd5, $urandom, 0, cap, end_rel, was_err, oe_cyc);
        stall_v[0] = 1'b0;
        checkOutput("timeout err", was_err, 1'b1);
        checkOutput("timeout err cycle", end_rel, 8);
        checkOutput("timeout oe cycles", oe_cyc, 0);
        applyStimulus(0, 6'd17, 32'h0, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("post-timeout frame", cap, 48'h510000000055);

        // Start pulse during bit 20 is ignored; next start on the cycle after done accepted.
        applyStimulus(0, 6'd0, 32'h0, 2 + 20 * 2 + 1, cap, end_rel, was_err, oe_cyc);
        checkOutput("poke frame", cap, 48'h400000000095);
        checkOutput("poke done cycle", end_rel, 2 + (48 + GAPB) * 2);
        applyStimulus(0, 6'd17, 32'h0, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("back-to-back frame", cap, 48'h510000000055);

        // Start sampled on the done edge itself is ignored.
        applyStimulus(1, 6'd8, 32'h000001AA, 2 + (48 + GAPB) - 1, cap, end_rel, was_err, oe_cyc);
        checkOutput("done-edge poke frame", cap, 48'h48000001AA87);
        repeat (4) @(negedge clk);
        checkOutput("done-edge start ignored", busy_v[1], 1'b0);

        // Reset in the middle of bit 30.
        idx_v[0]   = 6'd0;
        arg_v[0]   = 32'h0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2 + 30 * 2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst oe",     cmd_oe_v[0], 1'b0);
        checkOutput("async rst cmd_o",  cmd_o_v[0],  1'b1);
        checkOutput("async rst busy",   busy_v[0],   1'b0);
        checkOutput("async rst crc_en", crc_en_v[0], 1'b0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        checkOutput("no done after rst", dcnt, 0);
        applyStimulus(0, 6'd8, 32'h000001AA, 0, cap, end_rel, was_err, oe_cyc);
        checkOutput("post-rst frame", cap, 48'h48000001AA87);

        // Randomized commands with stray starts and occasional CRC stalls.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 6; n++) begin
                stall = ($urandom_range(0, 4) == 0);
                stall_v[d] = stall;
                endx = stall ? TMO : 2 + (48 + GAPB) * div_of(d);
                applyStimulus(d, 6'($urandom), $urandom, int'($urandom_range(1, endx - 1)),
                              cap, end_rel, was_err, oe_cyc);
                stall_v[d] = 1'b0;
                checkOutput($sformatf("dut%0d rand end cycle", d), end_rel, endx);
                checkOutput($sformatf("dut%0d rand end kind", d), was_err, stall);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #1000000;
        n_checks++;
        n_errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
